sccb_master: RTL

SCCB_MASTER -- requirements
Module: sccb_master

---
 rtl/sccb_pkg.sv | 22 ++
 rtl/sccb_qtimer.sv | 32 +++
 rtl/sccb_master.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB master: FSM state encoding,
// quarter-period phase encoding and the default slave address.
package sccb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    STOP,
    GAP
  } state_t;

  typedef enum logic [1:0] {
    P0,
    P1,
    P2,
    P3
  } phase_t;

  localparam logic [6:0] SCCB_DEV_ADDR = 7'h21;

endpackage

// File: rtl/sccb_qtimer.sv
// Quarter-SCL-period tick generator; restarting puts the count back to zero
// so every FSM state starts with a full quarter period.
module sccb_qtimer #(
  parameter int CLK_F  = 100_000_000,
  parameter int SCCB_F = 400_000
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic restart,
  output logic tick
);

  localparam int Q = CLK_F / (4 * SCCB_F);
  localparam int W = (Q > 1) ? $clog2(Q) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(Q - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sccb_master.sv
// SCCB (I2C-like) single-register read/write master with open-drain pins.
// Define SCCB_ACK_CHECK_EN to abort on a slave NACK and report it on o_nack.
module sccb_master
  import sccb_pkg::*;
#(
  parameter int         CLK_F      = 100_000_000,
  parameter int         SCCB_F     = 400_000,
  parameter logic [6:0] DEV_ADDR   = SCCB_DEV_ADDR,
  parameter int         ADDR_BYTES = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_req,
  input  logic                    i_rnw,
  input  logic [8*ADDR_BYTES-1:0] i_reg_addr,
  input  logic [7:0]              i_wdata,
  output logic                    o_ready,
  output logic                    o_done,
  output logic [7:0]              o_rdata,
  output logic                    o_nack,
  output logic                    o_scl,
  inout  wire                     io_sda
);

  localparam int Q = CLK_F / (4 * SCCB_F);

  generate
    if (Q < 2 || (ADDR_BYTES != 1 && ADDR_BYTES != 2)) begin : g_param_check
      $error("sccb_master: CLK_F/(4*SCCB_F) must be >= 2 and ADDR_BYTES 1 or 2");
    end
  endgenerate

  state_t                  state_q, state_d;
  phase_t                  phase_q, phase_d;
  logic [3:0]              bit_q, bit_d;
  logic [1:0]              byte_q, byte_d;
  logic                    second_q, second_d;
  logic                    rnw_q;
  logic [8*ADDR_BYTES-1:0] addr_q;
  logic [7:0]              wdata_q;
  logic [7:0]              rx_q;
  logic [7:0]              rdata_q;
  logic                    done_q;
  logic                    nack_q;
  logic                    scl_oe_q, scl_oe_d;
  logic                    sda_oe_q, sda_oe_d;

  logic        tick;
  logic        accept;
  logic        sample;
  logic        sda_in;
  logic        rx_byte;
  logic        last_byte;
  logic        finish;
  logic [7:0]  cur_byte;
  logic [15:0] addr_ext;
  logic [2:0]  bit_idx;

  sccb_qtimer #(
    .CLK_F (CLK_F),
    .SCCB_F(SCCB_F)
  ) u_qtimer (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .restart((state_d != state_q) || (state_q == IDLE)),
    .tick   (tick)
  );

  assign sda_in    = io_sda;
  assign accept    = (state_q == IDLE) && i_req;
  assign sample    = (state_q == BIT) && (phase_q == P1) && tick;
  assign finish    = (state_q == GAP) && (state_d == IDLE);
  assign rx_byte   = second_q && (byte_q == 2'd1);
  assign addr_ext  = 16'(addr_q);
  assign bit_idx   = 3'(4'd7 - bit_q);
  // The first segment ends after the address for reads, after the data for writes.
  assign last_byte = second_q ? (byte_q == 2'd1)
                              : (byte_q == (rnw_q ? 2'(ADDR_BYTES) : 2'(ADDR_BYTES + 1)));

  // Byte currently shifted out; register address goes MSB byte first.
  always_comb begin
    cur_byte = wdata_q;
    if (byte_q == 2'd0) begin
      cur_byte = {DEV_ADDR, second_q};
    end else if (byte_q == 2'(ADDR_BYTES)) begin
      cur_byte = addr_ext[7:0];
    end else if (byte_q < 2'(ADDR_BYTES)) begin
      cur_byte = addr_ext[15:8];
    end
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement leaves a value unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    second_d = second_q;
    unique case (state_q)
      IDLE: begin
        if (i_req) begin
          state_d  = START;
          phase_d  = P0;
          bit_d    = 4'd0;
          byte_d   = 2'd0;
          second_d = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (phase_q == P3) begin
            state_d = BIT;
            phase_d = P0;
          end else begin
            phase_d = phase_t'(phase_q + 2'd1);
          end
        end
      end
      BIT: begin
        if (tick) begin
          if (phase_q != P3) begin
            phase_d = phase_t'(phase_q + 2'd1);
          end else begin
            phase_d = P0;
            if (bit_q != 4'd8) begin
              bit_d = bit_q + 4'd1;
            end else begin
              bit_d = 4'd0;
              if (nack_q || last_byte) begin
                state_d = STOP;
              end else begin
                byte_d = byte_q + 2'd1;
              end
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (phase_q == P3) begin
            phase_d = P0;
            if (rnw_q && !second_q && !nack_q) begin
              state_d  = START;
              second_d = 1'b1;
              byte_d   = 2'd0;
            end else begin
              state_d = GAP;
            end
          end else begin
            phase_d = phase_t'(phase_q + 2'd1);
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (phase_q == P1) begin
            state_d = IDLE;
            phase_d = P0;
          end else begin
            phase_d = phase_t'(phase_q + 2'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin enables: 1 pulls the line low, 0 releases it.
  always_comb begin
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    unique case (state_q)
      START: begin
        sda_oe_d = 1'b1;
        scl_oe_d = (phase_q == P2) || (phase_q == P3);
      end
      BIT: begin
        scl_oe_d = (phase_q == P0) || (phase_q == P3);
        if (bit_q != 4'd8 && !rx_byte) begin
          sda_oe_d = !cur_byte[bit_idx];
        end
      end
      STOP: begin
        sda_oe_d = (phase_q == P0) || (phase_q == P1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      phase_q  <= P0;
      bit_q    <= 4'd0;
      byte_q   <= 2'd0;
      second_q <= 1'b0;
      rnw_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 8'h00;
      rx_q     <= 8'h00;
      rdata_q  <= 8'h00;
      done_q   <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      second_q <= second_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
      done_q   <= finish;
      if (accept) begin
        rnw_q   <= i_rnw;
        addr_q  <= i_reg_addr;
        wdata_q <= i_wdata;
      end
      if (sample && rx_byte && bit_q != 4'd8) begin
        rx_q <= {rx_q[6:0], sda_in};
      end
      if (finish && rnw_q && !nack_q) begin
        rdata_q <= rx_q;
      end
    end
  end

`ifdef SCCB_ACK_CHECK_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      nack_q <= 1'b0;
    end else if (accept) begin
      nack_q <= 1'b0;
    end else if (sample && bit_q == 4'd8 && !rx_byte && sda_in) begin
      nack_q <= 1'b1;
    end
  end
`else
  assign nack_q = 1'b0;
`endif

  assign o_ready = (state_q == IDLE);
  assign o_done  = done_q;
  assign o_rdata = rdata_q;
  assign o_nack  = nack_q;
  assign o_scl   = scl_oe_q ? 1'b0 : 1'bz;
  assign io_sda  = sda_oe_q ? 1'b0 : 1'bz;

endmodule
